// File: rtl/mips_cpu_pkg.sv
// Shared constants and ALU opcode encoding for the MIPS CPU datapath.
package mips_cpu_pkg;
  localparam int DATA_W    = 32;
  localparam int REG_COUNT = 32;

  typedef enum logic [4:0] {
    ALU_AND  = 5'd0,
    ALU_OR   = 5'd1,
    ALU_ADD  = 5'd2,
    ALU_SUB  = 5'd3,
    ALU_SLT  = 5'd4,
    ALU_XOR  = 5'd5,
    ALU_SLL  = 5'd6,
    ALU_SRL  = 5'd7,
    ALU_SRA  = 5'd8,
    ALU_SLLV = 5'd9,
    ALU_SRLV = 5'd10,
    ALU_SRAV = 5'd11,
    ALU_LUI  = 5'd12
  } aluop_t;
endpackage

// File: rtl/mips_cpu_alu_core.sv
// Combinational MIPS ALU; undefined opcodes yield zero.
module mips_cpu_alu_core
  import mips_cpu_pkg::*;
(
  input  logic [4:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [4:0]        sa,
  output logic [DATA_W-1:0] result,
  output logic              zero
);
  // Variable shifts only honour the low five bits of rs.
  logic [4:0] sav;
  assign sav = a[4:0];

  always_comb begin
    result = '0;
    case (aluop_t'(op))
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLT:  result = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = b << sa;
      ALU_SRL:  result = b >> sa;
      ALU_SRA:  result = $signed(b) >>> sa;
      ALU_SLLV: result = b << sav;
      ALU_SRLV: result = b >> sav;
      ALU_SRAV: result = $signed(b) >>> sav;
      ALU_LUI:  result = {b[15:0], 16'h0000};
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);
endmodule

// File: rtl/mips_cpu_alu_registers.sv
// MIPS register file (32x32, r0 hardwired zero) plus the ALU core.
// Define REG_BYPASS_EN to forward same-cycle write data to the read ports.
module mips_cpu_alu_registers #(
  parameter int DATA_W    = mips_cpu_pkg::DATA_W,
  parameter int REG_COUNT = mips_cpu_pkg::REG_COUNT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write,
  input  logic [4:0]        wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic [4:0]        rdAddrA,
  output logic [DATA_W-1:0] rdDataA,
  input  logic [4:0]        rdAddrB,
  output logic [DATA_W-1:0] rdDataB,
  output logic [DATA_W-1:0] register_v0,
  input  logic [4:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [4:0]        sa,
  output logic [DATA_W-1:0] result,
  output logic              zero
);
  logic [DATA_W-1:0] regs [REG_COUNT];
  logic [DATA_W-1:0] rd_a, rd_b, rd_v0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (write && wrAddr != 5'd0) begin
      regs[wrAddr] <= wrData;
    end
  end

  assign rd_a  = (rdAddrA == 5'd0) ? '0 : regs[rdAddrA];
  assign rd_b  = (rdAddrB == 5'd0) ? '0 : regs[rdAddrB];
  assign rd_v0 = regs[2];

`ifdef REG_BYPASS_EN
  // Forward only writes that will actually land at the next edge.
  logic wr_live;
  assign wr_live     = write && !rst && (wrAddr != 5'd0);
  assign rdDataA     = (wr_live && rdAddrA == wrAddr) ? wrData : rd_a;
  assign rdDataB     = (wr_live && rdAddrB == wrAddr) ? wrData : rd_b;
  assign register_v0 = (wr_live && wrAddr == 5'd2)    ? wrData : rd_v0;
`else
  assign rdDataA     = rd_a;
  assign rdDataB     = rd_b;
  assign register_v0 = rd_v0;
`endif

  mips_cpu_alu_core u_alu (
    .op     (op),
    .a      (a),
    .b      (b),
    .sa     (sa),
    .result (result),
    .zero   (zero)
  );
endmodule

// File: tb/tb_mips_cpu_alu_registers.sv
// Directed bench for the register file and ALU of mips_cpu_alu_registers.
module tb_mips_cpu_alu_registers;
  logic        clk = 1'b0;
  logic        rst, write;
  logic [4:0]  wrAddr, rdAddrA, rdAddrB, op, sa;
  logic [31:0] wrData, rdDataA, rdDataB, register_v0, a, b, result;
  logic        zero;
  int checks = 0;
  int errors = 0;

  mips_cpu_alu_registers dut (
    .clk(clk), .rst(rst), .write(write), .wrAddr(wrAddr), .wrData(wrData),
    .rdAddrA(rdAddrA), .rdDataA(rdDataA), .rdAddrB(rdAddrB), .rdDataB(rdDataB),
    .register_v0(register_v0), .op(op), .a(a), .b(b), .sa(sa),
    .result(result), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; write = 0; wrAddr = 0; wrData = 0; rdAddrA = 5; rdAddrB = 0;
    op = 0; a = 0; b = 0; sa = 0;
    tick(); tick();
    rst = 0;
    #1;
    checks++;
    if (rdDataA !== 32'h0) begin errors++; $display("FAIL reset_rdA got %h want %h", rdDataA, 32'h0); end
    checks++;
    if (register_v0 !== 32'h0) begin errors++; $display("FAIL reset_v0 got %h want %h", register_v0, 32'h0); end
  endtask

  task automatic test_write_read();
    logic [31:0] pre;
    write = 1; wrAddr = 5; wrData = 32'h12345678; rdAddrA = 5; rdAddrB = 0;
    #1;
`ifdef REG_BYPASS_EN
    pre = 32'h12345678;
`else
    pre = 32'h0;
`endif
    checks++;
    if (rdDataA !== pre) begin errors++; $display("FAIL pre_edge_rdA got %h want %h", rdDataA, pre); end
    tick();
    write = 0;
    #1;
    checks++;
    if (rdDataA !== 32'h12345678) begin errors++; $display("FAIL wr_rdA got %h want %h", rdDataA, 32'h12345678); end
    checks++;
    if (rdDataB !== 32'h0) begin errors++; $display("FAIL wr_rdB_r0 got %h want %h", rdDataB, 32'h0); end
    rst = 1;
    tick();
    rst = 0;
    #1;
    checks++;
    if (rdDataA !== 32'h0) begin errors++; $display("FAIL rst_clears got %h want %h", rdDataA, 32'h0); end
  endtask

  task automatic test_r0_v0();
    logic [31:0] pre;
    write = 1; wrAddr = 0; wrData = 32'hFFFFFFFF; rdAddrA = 0; rdAddrB = 0;
    tick();
    checks++;
    if (rdDataA !== 32'h0) begin errors++; $display("FAIL r0_write got %h want %h", rdDataA, 32'h0); end
    wrAddr = 2; wrData = 32'hDEADBEEF;
    #1;
`ifdef REG_BYPASS_EN
    pre = 32'hDEADBEEF;
`else
    pre = 32'h0;
`endif
    checks++;
    if (register_v0 !== pre) begin errors++; $display("FAIL v0_pre_edge got %h want %h", register_v0, pre); end
    tick();
    write = 0; rdAddrB = 2;
    #1;
    checks++;
    if (register_v0 !== 32'hDEADBEEF) begin errors++; $display("FAIL v0_post got %h want %h", register_v0, 32'hDEADBEEF); end
    checks++;
    if (rdDataB !== 32'hDEADBEEF) begin errors++; $display("FAIL r2_rdB got %h want %h", rdDataB, 32'hDEADBEEF); end
    checks++;
    if (rdDataA !== 32'h0) begin errors++; $display("FAIL r0_still_zero got %h want %h", rdDataA, 32'h0); end
  endtask

  task automatic test_alu();
    // {op, a, b, sa, expected}
    logic [4:0]  v_op [16] = '{5'd0, 5'd1, 5'd5, 5'd2, 5'd3, 5'd4, 5'd4, 5'd8,
                               5'd7, 5'd6, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd31};
    logic [31:0] v_a  [16] = '{32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hFFFFFFFF,
                               32'h3, 32'hFFFFFFFF, 32'h1, 32'h0,
                               32'h0, 32'h0, 32'h24, 32'hFFFFFFE4,
                               32'hFFFFFFE4, 32'h0, 32'hFFFFFFFF, 32'h12345678};
    logic [31:0] v_b  [16] = '{32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'h1,
                               32'h5, 32'h1, 32'hFFFFFFFF, 32'h80000000,
                               32'h80000000, 32'h1, 32'h1, 32'h80000000,
                               32'h80000000, 32'hFFFF8001, 32'hFFFFFFFF, 32'h1};
    logic [4:0]  v_sa [16] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd4,
                               5'd4, 5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd7};
    logic [31:0] v_r  [16] = '{32'hF000F000, 32'hFFF0FFF0, 32'h0FF00FF0, 32'h0,
                               32'hFFFFFFFE, 32'h1, 32'h0, 32'hF8000000,
                               32'h08000000, 32'h80000000, 32'h00000010, 32'h08000000,
                               32'hF8000000, 32'h80010000, 32'h0, 32'h0};
    for (int i = 0; i < 16; i++) begin
      op = v_op[i]; a = v_a[i]; b = v_b[i]; sa = v_sa[i];
      #1;
      checks++;
      if (result !== v_r[i]) begin
        errors++; $display("FAIL alu_result[%0d] op=%0d got %h want %h", i, op, result, v_r[i]);
      end
      checks++;
      if (zero !== (v_r[i] == 32'h0)) begin
        errors++; $display("FAIL alu_zero[%0d] op=%0d got %b want %b", i, op, zero, v_r[i] == 32'h0);
      end
    end
  endtask

  task automatic test_rst_write();
    write = 1; wrAddr = 7; wrData = 32'hAA; rdAddrA = 7;
    tick();
    rst = 1; wrData = 32'h55;
    #1;
    checks++;
    if (rdDataA !== 32'hAA) begin errors++; $display("FAIL rst_no_bypass got %h want %h", rdDataA, 32'hAA); end
    tick();
    rst = 0; write = 0;
    #1;
    checks++;
    if (rdDataA !== 32'h0) begin errors++; $display("FAIL rst_over_write got %h want %h", rdDataA, 32'h0); end
  endtask

  task automatic test_back_to_back();
    write = 1;
    wrAddr = 1; wrData = 32'h11111111; tick();
    wrAddr = 3; wrData = 32'h33333333; tick();
    wrAddr = 31; wrData = 32'hCAFEF00D; tick();
    write = 0; rdAddrA = 1; rdAddrB = 3;
    #1;
    checks++;
    if (rdDataA !== 32'h11111111) begin errors++; $display("FAIL b2b_r1 got %h want %h", rdDataA, 32'h11111111); end
    checks++;
    if (rdDataB !== 32'h33333333) begin errors++; $display("FAIL b2b_r3 got %h want %h", rdDataB, 32'h33333333); end
    rdAddrA = 31; rdAddrB = 31;
    #1;
    checks++;
    if (rdDataA !== 32'hCAFEF00D || rdDataB !== 32'hCAFEF00D) begin
      errors++; $display("FAIL same_reg_both got %h/%h want %h", rdDataA, rdDataB, 32'hCAFEF00D);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_r0_v0();
    test_alu();
    test_rst_write();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_cpu_alu_registers.md
MIPS_CPU_ALU_REGISTERS -- requirements
Module: mips_cpu_alu_registers

Interface
REQ-001 Parameter DATA_W, default 32, datapath width; only 32 is supported.
REQ-002 Parameter REG_COUNT, default 32, number of general registers; only 32 is supported.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 write  input  1  register write enable.
REQ-006 wrAddr  input  5  write register index.
REQ-007 wrData  input  32  write data.
REQ-008 rdAddrA  input  5  read port A index (rs).
REQ-009 rdDataA  output  32  read port A data.
REQ-010 rdAddrB  input  5  read port B index (rt).
REQ-011 rdDataB  output  32  read port B data.
REQ-012 register_v0  output  32  continuous copy of register 2 ($v0).
REQ-013 op  input  5  ALU operation code.
REQ-014 a  input  32  ALU operand A (rs value).
REQ-015 b  input  32  ALU operand B (rt value or sign-extended immediate).
REQ-016 sa  input  5  shift amount (instruction shamt field).
REQ-017 result  output  32  ALU result.
REQ-018 zero  output  1  high when result equals 0.

Function
REQ-019 The register file SHALL hold 32 x 32-bit registers; register 0 SHALL always read 0, and writes to it SHALL be discarded.
REQ-020 The block SHALL write wrData to register wrAddr on the rising clk edge when write=1, rst=0 and wrAddr!=0.
REQ-021 Both read ports SHALL be combinational from the addressed register, and both ports may address the same register.
REQ-022 The ALU SHALL be purely combinational, with a result latency of 0 cycles.
REQ-023 op codes: 0 AND a&b; 1 OR a|b; 2 ADD a+b mod 2^32 with no overflow trap; 3 SUB a-b mod 2^32; 4 SLT 1 if signed a<b, else 0; 5 XOR a^b.
REQ-024 op codes: 6 SLL b<<sa; 7 SRL b>>sa logical; 8 SRA b>>>sa arithmetic; 9 SLLV b<<a[4:0]; 10 SRLV b>>a[4:0] logical; 11 SRAV b>>>a[4:0] arithmetic; 12 LUI {b[15:0],16'h0000}.
REQ-025 op codes 13-31 SHALL produce result=0 and zero=1.
REQ-026 Shifts SHALL use only 5 bits of shift amount; a[31:5] SHALL be ignored.

Reset
REQ-027 When rst=1 at a rising edge, all 32 registers SHALL be set to 0, overriding any simultaneous write.
REQ-028 After reset, rdDataA, rdDataB and register_v0 SHALL read 0 until written.
REQ-029 Reset asserted mid-operation SHALL take effect at the next rising edge; the ALU has no state and is unaffected.

Configuration
REQ-030 Macro REG_BYPASS_EN: when defined, a read port whose address equals wrAddr, with write=1 and wrAddr!=0 and rst=0, SHALL return wrData in the same cycle, and register_v0 SHALL bypass likewise when wrAddr=2.
REQ-031 Without REG_BYPASS_EN, reads SHALL return the stored value, so new data is visible only after the write edge.

Structure
REQ-032 A shared package mips_cpu_pkg SHALL hold the aluop_t enum (codes 0-12 above) and the width constants DATA_W and REG_COUNT.
REQ-033 The ALU SHALL be one sub-module, mips_cpu_alu_core (ports op, a, b, sa, result, zero), instantiated once; the register file is coded in the top level.

Verification
REQ-034 Reset, write r5=0x12345678, read A=5 and B=0 -> rdDataA=0x12345678, rdDataB=0; then rst=1 for one edge -> rdDataA=0.
REQ-035 write r0=0xFFFFFFFF, write r2=0xDEADBEEF -> reading r0 gives 0, register_v0=0xDEADBEEF one edge after the write (same cycle with REG_BYPASS_EN).
REQ-036 ADD a=0xFFFFFFFF b=1 -> result=0, zero=1; SUB a=3 b=5 -> 0xFFFFFFFE, zero=0; SLT a=0xFFFFFFFF b=1 -> 1.
REQ-037 SRA b=0x80000000 sa=4 -> 0xF8000000; SRL same operands -> 0x08000000; SLLV a=0x00000024 b=1 -> 0x00000010.
REQ-038 LUI b=0xFFFF8001 -> 0x80010000; op=13 with any operands -> result=0, zero=1.
REQ-039 Write with rst=1 at the same edge, write r7=0x55 -> r7 reads 0 after the edge.
